// File: rtl/anubis_pkg.sv
// Shared types and constants for the ANUBIS round controller slice.
package anubis_pkg;

    localparam int BLOCK_W    = 128;
    localparam int KEY_IDX_W  = 5;
    localparam int MIN_ROUNDS = 12;
    localparam int MAX_ROUNDS = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEY0  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    function automatic logic [BLOCK_W-1:0] sigma_fn(
        input logic [BLOCK_W-1:0] idat,
        input logic [BLOCK_W-1:0] skey
    );
        return idat ^ skey;
    endfunction

endpackage

// File: rtl/anubis_round_controller_if.sv
// Host, key-schedule and round-core signals of the round controller.
interface anubis_round_controller_if;

    logic                                       start;
    logic [anubis_pkg::BLOCK_W-1:0]             din;
    logic                                       busy;
    logic                                       done;
    logic [anubis_pkg::BLOCK_W-1:0]             dout;
    logic                                       key_req;
    logic [anubis_pkg::KEY_IDX_W-1:0]           key_idx;
    logic                                       key_ack;
    logic [anubis_pkg::BLOCK_W-1:0]             key_data;
    logic [anubis_pkg::BLOCK_W-1:0]             core_in;
    logic                                       core_last;
    logic [anubis_pkg::BLOCK_W-1:0]             core_out;
    logic                                       err;

    // Controller side.
    modport slave (
        input  start, din, key_ack, key_data, core_out,
        output busy, done, dout, key_req, key_idx, core_in, core_last, err
    );

    // Wrapper / key schedule / round core side.
    modport master (
        output start, din, key_ack, key_data, core_out,
        input  busy, done, dout, key_req, key_idx, core_in, core_last, err
    );

endinterface

// File: rtl/anubis_sigma_xor.sv
// Round-key addition (sigma): bitwise XOR of the selected data with the key.
module anubis_sigma_xor
    import anubis_pkg::*;
(
    input  logic [BLOCK_W-1:0] idat,
    input  logic [BLOCK_W-1:0] skey,
    output logic [BLOCK_W-1:0] odat
);

    assign odat = sigma_fn(idat, skey);

endmodule

// File: rtl/anubis_round_controller.sv
// ANUBIS pass sequencer: key addition + NUM_ROUNDS rounds over a key req/ack handshake.
// Optional key-ack timeout abort is enabled by defining ANUBIS_KEY_TIMEOUT_EN.
module anubis_round_controller
    import anubis_pkg::*;
#(
    parameter int NUM_ROUNDS  = 12,
    parameter int KEY_TIMEOUT = 64
) (
    input logic                      clk,
    input logic                      reset_n,
    anubis_round_controller_if.slave bus
);

    localparam logic [KEY_IDX_W-1:0] LAST_ROUND = KEY_IDX_W'(NUM_ROUNDS);

    if (NUM_ROUNDS < MIN_ROUNDS || NUM_ROUNDS > MAX_ROUNDS) begin : g_bad_num_rounds
        $error("anubis_round_controller: NUM_ROUNDS must be within 12..18");
    end
    if (KEY_TIMEOUT < 1) begin : g_bad_key_timeout
        $error("anubis_round_controller: KEY_TIMEOUT must be at least 1");
    end

    fsm_state_t             fsm_r, fsm_nxt_s;
    logic [KEY_IDX_W-1:0]   round_r, round_nxt_s;
    logic [BLOCK_W-1:0]     state_r, dout_r;
    logic [BLOCK_W-1:0]     xor_in_s, xor_key_s, sigma_s;
    logic                   load_s, ack_s, timeout_s, dout_load_s;
    logic                   busy_r, done_r, key_req_r, core_last_r;
    logic [KEY_IDX_W-1:0]   key_idx_r;
    logic                   busy_nxt_s, done_nxt_s, key_req_nxt_s, core_last_nxt_s;
    logic [KEY_IDX_W-1:0]   key_idx_nxt_s;

    // key_ack only counts while a request is outstanding
    assign ack_s       = key_req_r & bus.key_ack;
    assign dout_load_s = (fsm_r == ST_ROUND) && ack_s && (round_r == LAST_ROUND);

    anubis_sigma_xor u_sigma_xor (
        .idat (xor_in_s),
        .skey (xor_key_s),
        .odat (sigma_s)
    );

`ifdef ANUBIS_KEY_TIMEOUT_EN
    localparam int TO_W = $clog2(KEY_TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt_r;
    logic            err_r, err_nxt_s;

    assign timeout_s = key_req_r && !bus.key_ack && (wait_cnt_r == TO_W'(KEY_TIMEOUT - 1));

    // Counts consecutive cycles spent waiting on key_ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= {TO_W{1'b0}};
        end else if (!key_req_r || bus.key_ack || timeout_s) begin
            wait_cnt_r <= {TO_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_r + TO_W'(1);
        end
    end

    // Sticky abort flag, cleared by the next accepted start.
    always_comb begin
        err_nxt_s = err_r;
        if ((fsm_r == ST_IDLE) && bus.start) begin
            err_nxt_s = 1'b0;
        end else if (timeout_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_nxt_s;
        end
    end

    assign bus.err = err_r;
`else
    assign timeout_s = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_r <= ST_IDLE;
        end else begin
            fsm_r <= fsm_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            ST_IDLE: begin
                if (bus.start) fsm_nxt_s = ST_KEY0;
                else           fsm_nxt_s = ST_IDLE;
            end
            ST_KEY0: begin
                if (timeout_s)  fsm_nxt_s = ST_IDLE;
                else if (ack_s) fsm_nxt_s = ST_ROUND;
                else            fsm_nxt_s = ST_KEY0;
            end
            ST_ROUND: begin
                if (timeout_s)                            fsm_nxt_s = ST_IDLE;
                else if (ack_s && round_r == LAST_ROUND) fsm_nxt_s = ST_DONE;
                else                                      fsm_nxt_s = ST_ROUND;
            end
            ST_DONE:  fsm_nxt_s = ST_IDLE;
            default:  fsm_nxt_s = ST_IDLE;
        endcase
    end

    // Sigma input mux and round-counter update; the counter saturates at the last round.
    always_comb begin
        round_nxt_s = round_r;
        xor_in_s    = state_r;
        xor_key_s   = {BLOCK_W{1'b0}};
        load_s      = 1'b0;
        case (fsm_r)
            ST_IDLE: begin
                xor_in_s = bus.din;
                if (bus.start) begin
                    load_s      = 1'b1;
                    round_nxt_s = {KEY_IDX_W{1'b0}};
                end else begin
                    load_s      = 1'b0;
                end
            end
            ST_KEY0: begin
                xor_key_s = bus.key_data;
                if (ack_s) begin
                    load_s      = 1'b1;
                    round_nxt_s = KEY_IDX_W'(1);
                end else begin
                    load_s      = 1'b0;
                end
            end
            ST_ROUND: begin
                xor_in_s  = bus.core_out;
                xor_key_s = bus.key_data;
                if (ack_s) begin
                    load_s = 1'b1;
                    if (round_r < LAST_ROUND) round_nxt_s = round_r + KEY_IDX_W'(1);
                    else                      round_nxt_s = round_r;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Cipher state, result and round counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= {BLOCK_W{1'b0}};
            dout_r  <= {BLOCK_W{1'b0}};
            round_r <= {KEY_IDX_W{1'b0}};
        end else begin
            if (load_s)      state_r <= sigma_s;
            if (dout_load_s) dout_r  <= sigma_s;
            round_r <= round_nxt_s;
        end
    end

    // Output decode from the upcoming state so the outputs can be registered.
    always_comb begin
        busy_nxt_s      = (fsm_nxt_s != ST_IDLE);
        done_nxt_s      = (fsm_nxt_s == ST_DONE);
        key_req_nxt_s   = (fsm_nxt_s == ST_KEY0) || (fsm_nxt_s == ST_ROUND);
        key_idx_nxt_s   = {KEY_IDX_W{1'b0}};
        core_last_nxt_s = 1'b0;
        if (fsm_nxt_s == ST_ROUND) begin
            key_idx_nxt_s   = round_nxt_s;
            core_last_nxt_s = (round_nxt_s == LAST_ROUND);
        end else begin
            key_idx_nxt_s   = {KEY_IDX_W{1'b0}};
            core_last_nxt_s = 1'b0;
        end
    end

    // Registered control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            key_req_r   <= 1'b0;
            key_idx_r   <= {KEY_IDX_W{1'b0}};
            core_last_r <= 1'b0;
        end else begin
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            key_req_r   <= key_req_nxt_s;
            key_idx_r   <= key_idx_nxt_s;
            core_last_r <= core_last_nxt_s;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.dout      = dout_r;
    assign bus.key_req   = key_req_r;
    assign bus.key_idx   = key_idx_r;
    assign bus.core_in   = state_r;
    assign bus.core_last = core_last_r;

endmodule

// File: tb/tb_anubis_round_controller.sv
// Scoreboard bench: 12-round and 18-round controllers with an identity round core.
module tb_anubis_round_controller;
    import anubis_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int ack_mode_a = 0;   // 0: tied high, 1: every 3rd cycle, 2: held low

    localparam logic [127:0] PAT_A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] PAT_B = 128'hdead_beef_0000_ffff_a5a5_5a5a_1357_9bdf;
    localparam logic [127:0] PAT_C = 128'h8000_0000_0000_0001_0f0f_0f0f_f0f0_f0f0;

    anubis_round_controller_if bus_a ();
    anubis_round_controller_if bus_b ();

    always @(posedge clk) cyc <= cyc + 1;

    // Identity round core and key schedule K[i] = {16{i}}
    assign bus_a.key_ack  = (ack_mode_a == 0) ? 1'b1 : ((ack_mode_a == 1) ? ((cyc % 3) == 0) : 1'b0);
    assign bus_a.key_data = {16{3'b000, bus_a.key_idx}};
    assign bus_a.core_out = bus_a.core_in;
    assign bus_b.key_ack  = 1'b1;
    assign bus_b.key_data = {16{3'b000, bus_b.key_idx}};
    assign bus_b.core_out = bus_b.core_in;

    anubis_round_controller #(.NUM_ROUNDS(12), .KEY_TIMEOUT(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
    anubis_round_controller #(.NUM_ROUNDS(18)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

    logic [127:0] q_a[$];
    logic [127:0] q_b[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor A: scoreboard pop on done, handshake and core_last rules every cycle
    logic       pok_a = 1'b0, preq_a = 1'b0, pack_a = 1'b0;
    logic [4:0] pidx_a = 5'd0;
    always @(negedge clk) begin
        if (bus_a.done) begin
            chk("busy_with_done_a", bus_a.busy, 1'b1);
            if (q_a.size() == 0) chk("unexpected_done_a", 1'b1, 1'b0);
            else                 chk("dout_a", bus_a.dout, q_a.pop_front());
        end
        if (pok_a && reset_n && preq_a && !bus_a.err) begin
            if (!pack_a) begin
                chk("req_hold_a", bus_a.key_req, 1'b1);
                chk("idx_stable_a", bus_a.key_idx, pidx_a);
            end else if (bus_a.key_req) begin
                chk("idx_step_a", bus_a.key_idx, pidx_a + 5'd1);
            end
        end
        chk("core_last_a", bus_a.core_last, bus_a.key_req && (bus_a.key_idx == 5'd12));
        pok_a  <= reset_n;
        preq_a <= bus_a.key_req;
        pack_a <= bus_a.key_ack;
        pidx_a <= bus_a.key_idx;
    end

    // Monitor B
    logic [4:0] pidx_b = 5'd0, max_idx_b = 5'd0;
    logic       preq_b = 1'b0;
    int         cl_cnt_b = 0;
    always @(negedge clk) begin
        if (bus_b.done) begin
            if (q_b.size() == 0) chk("unexpected_done_b", 1'b1, 1'b0);
            else                 chk("dout_b", bus_b.dout, q_b.pop_front());
        end
        if (reset_n && preq_b && bus_b.key_req) chk("idx_step_b", bus_b.key_idx, pidx_b + 5'd1);
        chk("core_last_b", bus_b.core_last, bus_b.key_req && (bus_b.key_idx == 5'd18));
        if (bus_b.core_last) cl_cnt_b <= cl_cnt_b + 1;
        if (bus_b.key_idx > max_idx_b) max_idx_b <= bus_b.key_idx;
        preq_b <= bus_b.key_req && reset_n;
        pidx_b <= bus_b.key_idx;
    end

    task automatic start_a(input logic [127:0] d, input logic push);
        @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.din   = d;
        if (push) q_a.push_back(d ^ {16{8'h0C}});
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input string name);
        int n = 0;
        while (!bus_a.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus_a.done) chk(name, 1'b0, 1'b1);
    endtask

    task automatic wait_idx_a(input logic [4:0] idx, input string name);
        int n = 0;
        while (!(bus_a.key_req && bus_a.key_idx == idx) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, bus_a.key_idx, idx);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int nb;
        bus_a.start = 1'b0; bus_a.din = 128'd0;
        bus_b.start = 1'b0; bus_b.din = 128'd0;

        #12;
        chk("rst_busy",    {bus_a.busy, bus_b.busy}, 2'b00);
        chk("rst_done",    {bus_a.done, bus_b.done}, 2'b00);
        chk("rst_key_req", {bus_a.key_req, bus_b.key_req}, 2'b00);
        chk("rst_key_idx", {bus_a.key_idx, bus_b.key_idx}, 10'd0);
        chk("rst_last_err", {bus_a.core_last, bus_a.err, bus_b.core_last, bus_b.err}, 4'd0);
        chk("rst_dout",    bus_a.dout, 128'd0);
        chk("rst_core_in", bus_a.core_in, 128'd0);
        #10 reset_n = 1'b1;

        // Zero-wait ack: latency and busy span
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.din = 128'd0;
        q_a.push_back({16{8'h0C}});
        @(posedge clk);
        @(negedge clk);
        bus_a.start = 1'b0;
        nb = bus_a.busy ? 1 : 0;
        n  = 0;
        while (!bus_a.done && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus_a.busy) nb++;
        end
        chk("latency_a", n, 13);
        chk("busy_span_a", nb, 14);
        @(negedge clk);
        chk("busy_clear_a", bus_a.busy, 1'b0);
        chk("done_single_a", bus_a.done, 1'b0);

        // Ack every third cycle
        ack_mode_a = 1;
        start_a(128'd0, 1'b1);
        wait_done_a(200, "done_wait_slow0");
        start_a(PAT_A, 1'b1);
        wait_done_a(200, "done_wait_slowA");

        // Restart attempt mid-pass is ignored
        ack_mode_a = 0;
        start_a(128'd0, 1'b1);
        wait_idx_a(5'd4, "reach_idx4");
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.din = {128{1'b1}};
        @(negedge clk);
        bus_a.start = 1'b0; bus_a.din = 128'd0;
        wait_done_a(100, "done_wait_restart");
        repeat (20) @(negedge clk);

        // Reset during round 5
        start_a(PAT_A, 1'b1);
        wait_idx_a(5'd5, "reach_idx5");
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy",    bus_a.busy, 1'b0);
        chk("midrst_key_req", bus_a.key_req, 1'b0);
        chk("midrst_dout",    bus_a.dout, 128'd0);
        chk("midrst_state",   bus_a.core_in, 128'd0);
        q_a.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;
        start_a(PAT_B, 1'b1);
        wait_done_a(100, "done_wait_postrst");

        // 18 rounds on DUT B
        @(negedge clk);
        bus_b.start = 1'b1; bus_b.din = 128'd0;
        q_b.push_back({16{8'h13}});
        @(posedge clk);
        @(negedge clk);
        bus_b.start = 1'b0;
        n = 0;
        while (!bus_b.done && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency_b", n, 19);
        @(negedge clk);
        chk("core_last_cnt_b", cl_cnt_b, 1);
        chk("max_idx_b", max_idx_b, 5'd18);

`ifdef ANUBIS_KEY_TIMEOUT_EN
        // Key ack never arrives: abort after 8 wait cycles
        ack_mode_a = 2;
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.din = {128{1'b1}};
        @(posedge clk);
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("to_busy_before", bus_a.busy, 1'b1);
        chk("to_err_before", bus_a.err, 1'b0);
        @(negedge clk);
        chk("to_busy_after", bus_a.busy, 1'b0);
        chk("to_err_after", bus_a.err, 1'b1);
        chk("to_key_req", bus_a.key_req, 1'b0);
        chk("to_dout_kept", bus_a.dout, PAT_B ^ {16{8'h0C}});
        repeat (5) @(negedge clk);
        chk("to_err_sticky", bus_a.err, 1'b1);
        ack_mode_a = 0;
        start_a(PAT_C, 1'b1);
        chk("to_err_cleared", bus_a.err, 1'b0);
        wait_done_a(100, "done_wait_after_to");
`else
        // Key ack never arrives: controller keeps waiting
        ack_mode_a = 2;
        start_a({128{1'b1}}, 1'b0);
        repeat (20) @(negedge clk);
        chk("wait_busy", bus_a.busy, 1'b1);
        chk("wait_key_req", bus_a.key_req, 1'b1);
        chk("wait_key_idx", bus_a.key_idx, 5'd0);
        chk("wait_err", bus_a.err, 1'b0);
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        ack_mode_a = 0;
        start_a(PAT_C, 1'b1);
        wait_done_a(100, "done_wait_after_wait");
`endif

        repeat (5) @(negedge clk);
        chk("sb_drain_a", q_a.size(), 0);
        chk("sb_drain_b", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
